// File: rtl/rst_cmd_pkg.sv
// Shared constants and types for the front-end command decoder.
package rst_cmd_pkg;

    localparam int unsigned LEN_W    = 8;
    localparam int unsigned DROP_W   = 16;
    localparam int unsigned PREFIX_W = 4;
    localparam int unsigned OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_RESET  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_SETLEN = 4'h1;

    localparam logic [PREFIX_W-1:0] DEFAULT_CMD_PREFIX = 4'hF;

    // Top byte of every incoming word.
    typedef struct packed {
        logic [PREFIX_W-1:0] prefix;
        logic [OPCODE_W-1:0] opcode;
    } cmd_hdr_t;

    // A programmed length of zero would silence the pulse; one cycle is the minimum.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] v);
        return (v == '0) ? LEN_W'(1) : v;
    endfunction

endpackage

// File: rtl/frontend_fifo.sv
// Parametrised synchronous FIFO with registered full/empty flags, reusable for front-end buffering.
module frontend_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              full_q;
    logic              empty_q;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is allowed only when a pop frees the slot in the same cycle.
    always_comb begin
        do_pop  = pop && !empty_q;
        do_push = push && (!full_q || do_pop);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rst_cmd_decoder.sv
// Front-end command decoder: splits command words into per-channel reset pulses,
// buffers all other words in a FIFO and counts words dropped while it is full.
module rst_cmd_decoder
    import rst_cmd_pkg::*;
#(
    parameter int unsigned         DATA_W     = 32,
    parameter int unsigned         NCH        = 4,
    parameter logic [PREFIX_W-1:0] CMD_PREFIX = DEFAULT_CMD_PREFIX,
    parameter int unsigned         RST_LEN    = 32,
    parameter int unsigned         DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic [NCH-1:0]    rst_out,
    output logic [DROP_W-1:0] drop_count
);

    cmd_hdr_t          hdr;
    logic              is_prefix;
    logic              cmd_reset;
    logic              cmd_setlen;
    logic              is_data;
    logic [NCH-1:0]    sel_mask;
    logic              pop;
    logic              push;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LEN_W-1:0]  pulse_len_q;
    logic [DROP_W-1:0] drop_q;

    // Word classification; unknown opcodes fall through to the data path.
    always_comb begin
        hdr        = cmd_hdr_t'(data_in[DATA_W-1 -: (PREFIX_W + OPCODE_W)]);
        is_prefix  = valid_in && (hdr.prefix == CMD_PREFIX);
        cmd_reset  = is_prefix && (hdr.opcode == OP_RESET);
        cmd_setlen = is_prefix && (hdr.opcode == OP_SETLEN);
        is_data    = valid_in && !cmd_reset && !cmd_setlen;
        sel_mask   = (data_in[NCH-1:0] == '0) ? '1 : data_in[NCH-1:0];
        pop        = ready && valid;
        push       = is_data && (!fifo_full || pop);
        drop       = is_data && fifo_full && !pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_len_q <= LEN_W'(RST_LEN);
        end else if (cmd_setlen) begin
            pulse_len_q <= clamp_len(data_in[LEN_W-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

    assign drop_count = drop_q;

    // Per-channel pulse counters; a retrigger reloads so the output never dips.
    for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
        logic [LEN_W-1:0] cnt_q;
        logic [LEN_W-1:0] cnt_d;
        logic             active_q;

        always_comb begin
            cnt_d = cnt_q;
            if (cmd_reset && sel_mask[i]) begin
                cnt_d = pulse_len_q;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - LEN_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q    <= '0;
                active_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                active_q <= (cnt_d != '0);
            end
        end

        assign rst_out[i] = active_q;
    end

    frontend_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_in),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (data)
    );

    assign valid = !fifo_empty;

endmodule

// File: tb/tb_rst_cmd_decoder.sv
// Self-checking bench for rst_cmd_decoder: directed table, hand sequences and randomized model comparison.
module tb_rst_cmd_decoder;

    localparam int DW    = 32;
    localparam int NC    = 4;
    localparam int DEP   = 4;
    localparam int PLEN  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready = 1'b0;
    logic [NC-1:0] rst_out;
    logic [15:0]   drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: pulse end cycle per channel, queue of buffered words, counters.
    longint        pend_end [NC];
    logic [DW-1:0] mq [$];
    int            mlen;
    int            mdrop;
    int            cyc = 0;

    logic [NC-1:0] samp_rst;
    logic          samp_valid;
    logic [DW-1:0] samp_data;
    logic [15:0]   samp_drop;

    typedef struct {
        logic          vi;
        logic [DW-1:0] di;
        logic          rdy;
        logic [NC-1:0] e_rst;
        logic          e_valid;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vt [14];

    rst_cmd_decoder #(
        .DATA_W     (DW),
        .NCH        (NC),
        .CMD_PREFIX (4'hF),
        .RST_LEN    (PLEN),
        .DEPTH      (DEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .rst_out    (rst_out),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) pend_end[i] = -1;
        mq.delete();
        mlen  = PLEN;
        mdrop = 0;
    endtask

    task automatic model_apply(input logic vi, input logic [DW-1:0] di, input logic rdy);
        logic       do_pop;
        logic       do_push;
        logic [3:0] mask;
        do_pop  = rdy && (mq.size() > 0);
        do_push = 1'b0;
        if (vi) begin
            if (di[31:28] == 4'hF && di[27:24] == 4'h0) begin
                mask = di[3:0];
                if (mask == 4'h0) mask = 4'hF;
                for (int i = 0; i < NC; i++)
                    if (mask[i]) pend_end[i] = longint'(cyc) + longint'(mlen);
            end else if (di[31:28] == 4'hF && di[27:24] == 4'h1) begin
                mlen = (di[7:0] == 8'h0) ? 1 : int'(di[7:0]);
            end else if (mq.size() < DEP || do_pop) begin
                do_push = 1'b1;
            end else if (mdrop < 65535) begin
                mdrop++;
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(di);
    endtask

    // One clock cycle: sample and compare outputs, then drive this cycle's inputs.
    task automatic step(input logic vi, input logic [DW-1:0] di, input logic rdy);
        logic [NC-1:0] exp_r;
        @(negedge clk);
        samp_rst   = rst_out;
        samp_valid = valid;
        samp_data  = data;
        samp_drop  = drop_count;
        for (int i = 0; i < NC; i++) exp_r[i] = (longint'(cyc) <= pend_end[i]);
        chk("rst_out", 64'(samp_rst), 64'(exp_r));
        chk("valid", 64'(samp_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) chk("data", 64'(samp_data), 64'(mq[0]));
        chk("drop_count", 64'(samp_drop), 64'(mdrop));
        valid_in = vi;
        data_in  = di;
        ready    = rdy;
        model_apply(vi, di, rdy);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_in = 1'b0;
        data_in  = '0;
        ready    = 1'b0;
        rst      = 1'b0;
        #1;
        chk("reset_rst_out", 64'(rst_out), 64'(0));
        chk("reset_valid", 64'(valid), 64'(0));
        chk("reset_data", 64'(data), 64'(0));
        chk("reset_drop", 64'(drop_count), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int hi;
        int rises;
        logic prev;

        vt[0]  = '{1'b1, 32'hF100_0003, 1'b0, 4'h0, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 32'hF000_0001, 1'b0, 4'h0, 1'b0, 32'h0};
        vt[2]  = '{1'b1, 32'h0000_00AA, 1'b0, 4'h1, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 32'h0,         1'b0, 4'h1, 1'b1, 32'h0000_00AA};
        vt[4]  = '{1'b0, 32'h0,         1'b0, 4'h1, 1'b1, 32'h0000_00AA};
        vt[5]  = '{1'b0, 32'h0,         1'b1, 4'h0, 1'b1, 32'h0000_00AA};
        vt[6]  = '{1'b1, 32'hF200_1234, 1'b1, 4'h0, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 32'h0,         1'b1, 4'h0, 1'b1, 32'hF200_1234};
        vt[8]  = '{1'b1, 32'hF000_0000, 1'b0, 4'h0, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 32'hF000_0004, 1'b0, 4'hF, 1'b0, 32'h0};
        vt[10] = '{1'b0, 32'h0,         1'b0, 4'hF, 1'b0, 32'h0};
        vt[11] = '{1'b0, 32'h0,         1'b0, 4'hF, 1'b0, 32'h0};
        vt[12] = '{1'b0, 32'h0,         1'b0, 4'h4, 1'b0, 32'h0};
        vt[13] = '{1'b0, 32'h0,         1'b0, 4'h0, 1'b0, 32'h0};

        model_reset();
        do_reset();

        // Directed table
        for (int k = 0; k < 14; k++) begin
            step(vt[k].vi, vt[k].di, vt[k].rdy);
            chk($sformatf("tbl%0d_rst", k), 64'(samp_rst), 64'(vt[k].e_rst));
            chk($sformatf("tbl%0d_valid", k), 64'(samp_valid), 64'(vt[k].e_valid));
            if (vt[k].e_valid) chk($sformatf("tbl%0d_data", k), 64'(samp_data), 64'(vt[k].e_data));
        end

        // Power-up length: all channels, exactly 32 cycles
        do_reset();
        step(1'b1, 32'hF000_0000, 1'b0);
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, '0, 1'b0);
            if (k == 0) chk("all_latency", 64'(samp_rst), 64'hF);
            if (samp_rst == 4'hF) hi++;
        end
        chk("all_len32", 64'(hi), 64'(32));

        // SETLEN=5 then channel 1 only
        step(1'b1, 32'hF100_0005, 1'b0);
        step(1'b1, 32'hF000_0002, 1'b0);
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, '0, 1'b0);
            if (samp_rst[1]) hi++;
            if (samp_rst[0] | samp_rst[2] | samp_rst[3]) chk("ch1_only", 64'(samp_rst), 64'h2);
        end
        chk("ch1_len5", 64'(hi), 64'(5));

        // SETLEN=0 clamps to one cycle
        step(1'b1, 32'hF100_0000, 1'b0);
        step(1'b1, 32'hF000_0008, 1'b0);
        hi = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '0, 1'b0);
            if (samp_rst[3]) hi++;
        end
        chk("len0_clamp", 64'(hi), 64'(1));

        // Retrigger at cycle 20 of the pulse extends to 32 past the retrigger
        step(1'b1, 32'hF100_0020, 1'b0);
        step(1'b1, 32'hF000_0001, 1'b0);
        hi = 0;
        rises = 0;
        prev = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            if (k == 20) step(1'b1, 32'hF000_0001, 1'b0);
            else step(1'b0, '0, 1'b0);
            if (samp_rst[0]) hi++;
            if (samp_rst[0] && !prev) rises++;
            prev = samp_rst[0];
        end
        chk("retrig_len", 64'(hi), 64'(52));
        chk("retrig_one_run", 64'(rises), 64'(1));

        // Six words into a 4-deep FIFO with no consumer
        do_reset();
        for (int k = 1; k <= 6; k++) step(1'b1, DW'(k), 1'b0);
        step(1'b0, '0, 1'b0);
        chk("drop_two", 64'(samp_drop), 64'(2));
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, '0, 1'b1);
            chk("drain_valid", 64'(samp_valid), 64'(1));
            chk("drain_data", 64'(samp_data), 64'(k));
        end
        step(1'b0, '0, 1'b0);
        chk("drain_empty", 64'(samp_valid), 64'(0));

        // Command while full, then data with a simultaneous pop
        do_reset();
        for (int k = 1; k <= 4; k++) step(1'b1, DW'(k), 1'b0);
        step(1'b1, 32'hF000_0001, 1'b0);
        step(1'b1, 32'h0000_0077, 1'b1);
        chk("full_cmd_exec", 64'(samp_rst[0]), 64'(1));
        step(1'b0, '0, 1'b0);
        chk("full_push_pop_drop", 64'(samp_drop), 64'(0));
        chk("full_push_pop_head", 64'(samp_data), 64'(2));

        // Asynchronous reset mid-pulse with FIFO non-empty
        step(1'b1, 32'hF000_0000, 1'b0);
        step(1'b1, 32'h0000_0055, 1'b0);
        step(1'b0, '0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_out", 64'(rst_out), 64'(0));
        chk("async_valid", 64'(valid), 64'(0));
        chk("async_drop", 64'(drop_count), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic [DW-1:0] w;
            int            sel;
            sel = int'($urandom_range(0, 99));
            w   = $urandom;
            if (sel < 15)      w = {8'hF0, 20'h0, 4'($urandom_range(0, 15))};
            else if (sel < 22) w = {8'hF1, 16'h0, 8'($urandom_range(0, 12))};
            else if (sel < 26) w = {4'hF, 4'($urandom_range(2, 15)), 24'($urandom)};
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
